// File: rtl/layer_wr_ctrl.sv
// Byte-stream write controller: decodes command/data bytes into one-hot RAM writes
// for the colour layers and the config bank, with cascaded pixel/channel/layer counters.
module layer_wr_ctrl #(
    parameter int N_LAYERS = 8,
    parameter int N_PIXELS = 64,
    parameter int BPP      = 3,
    localparam int AW      = $clog2(N_PIXELS)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              dc_in,
    input  logic              byte_rdy_in,
    input  logic [7:0]        byte_data_in,
    output logic [N_LAYERS:0] wr_en_out,
    output logic [AW-1:0]     wr_addr_out,
    output logic [3:0]        wr_byte_en_out,
    output logic [7:0]        wr_data_out,
    output logic              wr_done_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CONF  = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_LSEL  = 3'd4;
    localparam logic [2:0] S_LDATA = 3'd5;

    localparam logic [N_LAYERS:0] WE_ONE   = {{N_LAYERS{1'b0}}, 1'b1};
    localparam logic [N_LAYERS:0] WE_CFG   = {1'b1, {N_LAYERS{1'b0}}};
    localparam logic [AW:0]       CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]       CNT_CONF = (AW+1)'(4);
    localparam logic [AW:0]       CNT_PIX  = (AW+1)'(N_PIXELS);
    localparam logic [AW-1:0]     PIX_ONE  = AW'(1);
    localparam logic [AW-1:0]     PIX_LAST = AW'(N_PIXELS - 1);
    localparam logic [1:0]        CH_LAST  = 2'(BPP - 1);
    localparam logic [3:0]        LAY_LAST = 4'(N_LAYERS - 1);
    localparam logic [7:0]        NL_BYTE  = 8'(N_LAYERS);

    logic [2:0]          state_r, state_s;
    logic [AW:0]         cnt_r, cnt_s;
    logic [1:0]          chan_r, chan_s;
    logic [AW-1:0]       pix_r, pix_s;
    logic [3:0]          lay_r, lay_s;
    logic                fin_r, fin_s;
    logic                done_pend_r;
    logic                done_set_s;
    logic [N_LAYERS:0]   wr_en_s;
    logic [AW-1:0]       addr_s;
    logic [3:0]          be_s;
    logic [7:0]          data_s;

    // Next-state, counter and write-port decode for the byte accepted this cycle
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        chan_s     = chan_r;
        pix_s      = pix_r;
        lay_s      = lay_r;
        fin_s      = fin_r;
        wr_en_s    = '0;
        be_s       = 4'b0000;
        addr_s     = wr_addr_out;
        data_s     = wr_data_out;
        done_set_s = 1'b0;
        if (byte_rdy_in) begin
            if (!dc_in) begin
                cnt_s  = '0;
                chan_s = 2'b00;
                pix_s  = '0;
                lay_s  = 4'h0;
                fin_s  = 1'b0;
                case (byte_data_in)
                    8'h2a:   state_s = S_CONF;
                    8'h2b:   state_s = S_ADDR;
                    8'h2c:   state_s = S_DATA;
                    8'h2d:   state_s = S_LSEL;
                    default: state_s = S_IDLE;
                endcase
            end else begin
                case (state_r)
                    S_CONF: begin
                        if (cnt_r < CNT_CONF) begin
                            wr_en_s = WE_CFG;
                            addr_s  = '0;
                            be_s    = 4'b0001 << cnt_r[1:0];
                            data_s  = byte_data_in;
                            cnt_s   = cnt_r + CNT_ONE;
                        end else begin
                            cnt_s = cnt_r;
                        end
                    end
                    S_ADDR: begin
                        if (cnt_r < CNT_PIX) begin
                            wr_en_s = WE_CFG;
                            addr_s  = {2'b00, cnt_r[AW-1:2]} + PIX_ONE;
                            be_s    = 4'b0001 << cnt_r[1:0];
                            data_s  = byte_data_in;
                            cnt_s   = cnt_r + CNT_ONE;
                        end else begin
                            cnt_s = cnt_r;
                        end
                    end
                    S_DATA, S_LDATA: begin
                        if (!fin_r) begin
                            wr_en_s = WE_ONE << lay_r;
                            addr_s  = pix_r;
                            be_s    = 4'b0001 << chan_r;
                            data_s  = byte_data_in;
                            // Channel rolls into pixel, pixel into layer; the final byte
                            // freezes everything at the terminal count.
                            if (chan_r == CH_LAST) begin
                                if (pix_r == PIX_LAST) begin
                                    if ((state_r == S_LDATA) || (lay_r == LAY_LAST)) begin
                                        fin_s      = 1'b1;
                                        done_set_s = 1'b1;
                                    end else begin
                                        chan_s = 2'b00;
                                        pix_s  = '0;
                                        lay_s  = lay_r + 4'h1;
                                    end
                                end else begin
                                    chan_s = 2'b00;
                                    pix_s  = pix_r + PIX_ONE;
                                end
                            end else begin
                                chan_s = chan_r + 2'b01;
                            end
                        end else begin
                            fin_s = fin_r;
                        end
                    end
                    S_LSEL: begin
                        if (byte_data_in < NL_BYTE) begin
                            lay_s   = byte_data_in[3:0];
                            state_s = S_LDATA;
                        end else begin
                            state_s = S_IDLE;
                        end
                    end
                    default: state_s = state_r;
                endcase
            end
        end else begin
            state_s = state_r;
        end
    end

    // State, counters and registered write port; done is delayed one cycle past the last write
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r        <= S_IDLE;
            cnt_r          <= '0;
            chan_r         <= 2'b00;
            pix_r          <= '0;
            lay_r          <= 4'h0;
            fin_r          <= 1'b0;
            done_pend_r    <= 1'b0;
            wr_en_out      <= '0;
            wr_addr_out    <= '0;
            wr_byte_en_out <= 4'b0000;
            wr_data_out    <= 8'h00;
            wr_done_out    <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            chan_r         <= chan_s;
            pix_r          <= pix_s;
            lay_r          <= lay_s;
            fin_r          <= fin_s;
            done_pend_r    <= done_set_s;
            wr_en_out      <= wr_en_s;
            wr_addr_out    <= addr_s;
            wr_byte_en_out <= be_s;
            wr_data_out    <= data_s;
            wr_done_out    <= done_pend_r;
        end
    end

endmodule

// File: tb/tb_layer_wr_ctrl.sv
// Directed bench for layer_wr_ctrl: a GRB instance (defaults) and a GRBW instance share stimulus.
module tb_layer_wr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dc;
    logic       rdy;
    logic [7:0] bd;

    logic [8:0] we,  we4;
    logic [5:0] addr, addr4;
    logic [3:0] be,  be4;
    logic [7:0] dat, dat4;
    logic       done, done4;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    layer_wr_ctrl dut (
        .clk_in(clk), .rst_n_in(rst_n), .dc_in(dc), .byte_rdy_in(rdy), .byte_data_in(bd),
        .wr_en_out(we), .wr_addr_out(addr), .wr_byte_en_out(be), .wr_data_out(dat),
        .wr_done_out(done)
    );

    layer_wr_ctrl #(.N_LAYERS(8), .N_PIXELS(64), .BPP(4)) dut4 (
        .clk_in(clk), .rst_n_in(rst_n), .dc_in(dc), .byte_rdy_in(rdy), .byte_data_in(bd),
        .wr_en_out(we4), .wr_addr_out(addr4), .wr_byte_en_out(be4), .wr_data_out(dat4),
        .wr_done_out(done4)
    );

    typedef struct {
        logic       v;
        logic       c;
        logic [7:0] d;
        logic [8:0] we;
        logic [5:0] addr;
        logic [3:0] be;
        logic [7:0] dat;
        logic       done;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Presents one cycle of input starting at a falling edge; returns at the next falling edge,
    // where the registered result of that cycle is visible.
    task automatic step(input logic v, input logic c, input logic [7:0] d);
        rdy = v;
        dc  = c;
        bd  = d;
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 8'h2a, 9'h000, 6'd0, 4'h0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'h01, 9'h100, 6'd0, 4'h1, 8'h01, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 8'h12, 9'h100, 6'd0, 4'h2, 8'h12, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h00, 9'h000, 6'd0, 4'h0, 8'h12, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 8'h23, 9'h100, 6'd0, 4'h4, 8'h23, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 8'h34, 9'h100, 6'd0, 4'h8, 8'h34, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 8'h55, 9'h000, 6'd0, 4'h0, 8'h34, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h99, 9'h000, 6'd0, 4'h0, 8'h34, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 8'haa, 9'h000, 6'd0, 4'h0, 8'h34, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'h2d, 9'h000, 6'd0, 4'h0, 8'h34, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 8'h08, 9'h000, 6'd0, 4'h0, 8'h34, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 8'h11, 9'h000, 6'd0, 4'h0, 8'h34, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'h2d, 9'h000, 6'd0, 4'h0, 8'h34, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 8'h03, 9'h000, 6'd0, 4'h0, 8'h34, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 8'hc4, 9'h008, 6'd0, 4'h1, 8'hc4, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 8'hc5, 9'h008, 6'd0, 4'h2, 8'hc5, 1'b0};

        rst_n = 1'b0;
        rdy   = 1'b0;
        dc    = 1'b0;
        bd    = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_we",   32'(we),   32'h0);
        check("reset_addr", 32'(addr), 32'h0);
        check("reset_be",   32'(be),   32'h0);
        check("reset_dat",  32'(dat),  32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_we4",  32'(we4),  32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 16; k++) begin
            step(tbl[k].v, tbl[k].c, tbl[k].d);
            check($sformatf("tbl%0d_we", k),   32'(we),   32'(tbl[k].we));
            check($sformatf("tbl%0d_addr", k), 32'(addr), 32'(tbl[k].addr));
            check($sformatf("tbl%0d_be", k),   32'(be),   32'(tbl[k].be));
            check($sformatf("tbl%0d_dat", k),  32'(dat),  32'(tbl[k].dat));
            check($sformatf("tbl%0d_done", k), 32'(done), 32'(tbl[k].done));
        end

        // Address map: 64 bytes into config words 1..16, then one ignored byte
        step(1'b1, 1'b0, 8'h2b);
        check("addr_cmd_we", 32'(we), 32'h0);
        for (int j = 0; j < 64; j++) begin
            step(1'b1, 1'b1, 8'(j));
            check("addr_we",   32'(we),   32'h100);
            check("addr_addr", 32'(addr), 32'(1 + j / 4));
            check("addr_be",   32'(be),   32'(1 << (j % 4)));
            check("addr_dat",  32'(dat),  32'(j));
        end
        step(1'b1, 1'b1, 8'hff);
        check("addr_extra_we",   32'(we),   32'h0);
        check("addr_extra_be",   32'(be),   32'h0);
        check("addr_extra_addr", 32'(addr), 32'd16);
        check("addr_extra_dat",  32'(dat),  32'd63);

        // Full frame across all 8 layers, GRB
        step(1'b1, 1'b0, 8'h2c);
        for (int i = 0; i < 1536; i++) begin
            step(1'b1, 1'b1, 8'(i));
            check("data_we",   32'(we),   32'(1 << (i / 192)));
            check("data_addr", 32'(addr), 32'((i / 3) % 64));
            check("data_be",   32'(be),   32'(1 << (i % 3)));
            check("data_dat",  32'(dat),  32'(i % 256));
            check("data_done", 32'(done), 32'h0);
        end
        step(1'b1, 1'b1, 8'h5a);
        check("data_extra_we",   32'(we),   32'h0);
        check("data_done_pulse", 32'(done), 32'h1);
        step(1'b1, 1'b1, 8'h5b);
        check("data_extra2_we",  32'(we),   32'h0);
        check("data_done_once",  32'(done), 32'h0);

        // Single-layer stream on the GRBW instance, layer 5
        step(1'b1, 1'b0, 8'h2d);
        step(1'b1, 1'b1, 8'h05);
        check("lsel_we4", 32'(we4), 32'h0);
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b1, 8'(i));
            check("ldata_we4",   32'(we4),   32'h020);
            check("ldata_addr4", 32'(addr4), 32'(i / 4));
            check("ldata_be4",   32'(be4),   32'(1 << (i % 4)));
            check("ldata_done4", 32'(done4), 32'h0);
        end
        step(1'b1, 1'b1, 8'haa);
        check("ldata_extra_we4", 32'(we4),   32'h0);
        check("ldata_done4_pulse", 32'(done4), 32'h1);
        step(1'b0, 1'b1, 8'h00);
        check("ldata_done4_once", 32'(done4), 32'h0);
        step(1'b1, 1'b0, 8'h2d);
        step(1'b1, 1'b1, 8'h08);
        step(1'b1, 1'b1, 8'h12);
        check("lsel_bad_we4", 32'(we4), 32'h0);
        step(1'b1, 1'b1, 8'h13);
        check("lsel_bad_we4b", 32'(we4), 32'h0);

        // Abort a frame with a command: no done, config stream restarts at byte 0
        step(1'b1, 1'b0, 8'h2c);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b1, 8'(i));
        end
        check("abort_last_we", 32'(we), 32'(1 << 0));
        step(1'b1, 1'b0, 8'h2a);
        check("abort_cmd_we",   32'(we),   32'h0);
        check("abort_cmd_done", 32'(done), 32'h0);
        step(1'b1, 1'b1, 8'h77);
        check("abort_cfg_we",   32'(we),   32'h100);
        check("abort_cfg_addr", 32'(addr), 32'h0);
        check("abort_cfg_be",   32'(be),   32'h1);
        check("abort_cfg_dat",  32'(dat),  32'h77);
        check("abort_cfg_done", 32'(done), 32'h0);
        step(1'b0, 1'b1, 8'h00);
        check("abort_idle_done", 32'(done), 32'h0);

        // Reset in the middle of a data stream
        step(1'b1, 1'b0, 8'h2c);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 8'(8'h80 + i));
        end
        check("mid_we_before", 32'(we), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_we",   32'(we),   32'h0);
        check("rst_mid_addr", 32'(addr), 32'h0);
        check("rst_mid_be",   32'(be),   32'h0);
        check("rst_mid_dat",  32'(dat),  32'h0);
        check("rst_mid_done", 32'(done), 32'h0);
        check("rst_mid_we4",  32'(we4),  32'h0);
        rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 8'(8'h40 + i));
            check("post_rst_we", 32'(we), 32'h0);
            check("post_rst_be", 32'(be), 32'h0);
        end
        step(1'b0, 1'b1, 8'h00);
        check("post_rst_done", 32'(done), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/layer_wr_ctrl.md
LAYER_WR_CTRL -- requirements
Module: layer_wr_ctrl

Interface
REQ-001 Parameter N_LAYERS, default 8: number of colour layer RAMs, range 1..16.
REQ-002 Parameter N_PIXELS, default 64: pixels per layer, power of 2, range 8..256.
REQ-003 Parameter BPP, default 3: bytes per pixel, 3 (GRB) or 4 (GRBW).
REQ-004 Localparam AW = clog2(N_PIXELS).
REQ-005 clk_in  input  1: single clock; all logic rising-edge.
REQ-006 rst_n_in  input  1: asynchronous, active-low reset.
REQ-007 dc_in  input  1: 0 = command byte, 1 = data byte; sampled with byte_rdy_in.
REQ-008 byte_rdy_in  input  1: byte strobe; each high cycle = one byte.
REQ-009 byte_data_in  input  8: byte value.
REQ-010 wr_en_out  output  N_LAYERS+1: one-hot write enable; bits 0..N_LAYERS-1 = colour layers, bit N_LAYERS = config bank.
REQ-011 wr_addr_out  output  AW: word address.
REQ-012 wr_byte_en_out  output  4: one-hot byte lane within the 32-bit word.
REQ-013 wr_data_out  output  8: registered copy of the written byte.
REQ-014 wr_done_out  output  1: one-cycle pulse on frame/layer completion.

Function
REQ-015 All outputs registered; a write appears exactly 1 cycle after the byte_rdy_in cycle that carries it, for exactly 1 cycle.
REQ-016 States: IDLE, CONF, ADDR, DATA, LSEL, LDATA.
REQ-017 Any command byte (dc_in=0) from any state resets byte counters, issues no write, and selects: 0x2a->CONF, 0x2b->ADDR, 0x2c->DATA, 0x2d->LSEL, other->IDLE.
REQ-018 Data bytes in IDLE are ignored.
REQ-019 CONF: data byte k (0..3) -> wr_en_out[N_LAYERS]=1, wr_addr_out=0, wr_byte_en_out=1<<k; bytes with k>=4 are ignored.
REQ-020 ADDR: data byte j (0..N_PIXELS-1) -> config bank, wr_addr_out=1+j/4, wr_byte_en_out=1<<(j%4); bytes with j>=N_PIXELS are ignored.
REQ-021 DATA: byte i -> layer L=i/(N_PIXELS*BPP), pixel P=(i/BPP)%N_PIXELS, channel C=i%BPP; wr_en_out=1<<L, wr_addr_out=P, wr_byte_en_out=1<<C.
REQ-022 DATA indexing SHALL use cascaded channel/pixel/layer counters, not dividers.
REQ-023 DATA: wr_done_out pulses in the cycle after the write of byte N_LAYERS*N_PIXELS*BPP-1; further data bytes are ignored until the next command.
REQ-024 LSEL: first data byte is the layer index; if < N_LAYERS go to LDATA with that layer, else go to IDLE.
REQ-025 LDATA: byte i -> fixed selected layer, pixel i/BPP, channel i%BPP; wr_done_out pulses after byte N_PIXELS*BPP-1; extra bytes are ignored.
REQ-026 A command arriving before completion aborts the stream; no wr_done_out pulse is issued.
REQ-027 Counters SHALL NOT wrap; the terminal count saturates until the next command.
REQ-028 Non-write cycles: wr_en_out=0, wr_byte_en_out=0; wr_addr_out and wr_data_out hold their last value.

Reset
REQ-029 Asserting rst_n_in at any time forces state IDLE, all counters 0, all outputs 0, and cancels any pending write or done pulse.
REQ-030 After deassertion, the first accepted byte SHALL be processed from IDLE.

Verification
REQ-031 0x2a, then data 01,12,23,34 -> four config-bank writes at addr 0, byte_en 1,2,4,8, data 01,12,23,34; fifth data byte produces no write.
REQ-032 0x2b, then 64 bytes 0..63 (N_PIXELS=64) -> config-bank writes at addr 1..16, byte_en cycling 1,2,4,8, data = index.
REQ-033 0x2c, then 1536 bytes (defaults) -> byte 0: wr_en=0x001, addr 0, byte_en 1; byte 191: wr_en=0x001, addr 63, byte_en 4; byte 192: wr_en=0x002, addr 0; byte 1535: wr_en=0x080, addr 63, byte_en 4; one wr_done_out pulse; byte 1536 produces no write.
REQ-034 BPP=4: 0x2d, data 05, then 256 bytes -> all writes have wr_en=0x020, byte_en cycling 1,2,4,8, addr 0..63; done pulses once. 0x2d followed by 0x08 -> subsequent data ignored.
REQ-035 0x2c, 100 data bytes, then 0x2a -> no wr_done_out pulse; the next data byte writes config byte 0.
REQ-036 Reset asserted mid-DATA -> outputs 0 within the same cycle; after release, data bytes without a command produce no writes.
